// File: rtl/ttlc_io_arb.sv
// Shares the bit-addressed TTLC I/O port between the core (priority) and host byte transfers.
// Define TTLC_ARB_STARVE_EN to compile in the forced host slot after HOST_WAIT_MAX lost cycles.
module ttlc_io_arb #(
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       core_req,
    input  logic [7:0] core_addr,
    input  logic       core_we,
    input  logic       core_wdata,
    output logic       core_rdata,
    output logic       core_stall,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_busy,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic [7:0] io_addr,
    output logic       io_we,
    output logic       io_wdata,
    input  logic       io_rdata
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       forced;
    logic       host_slot;
    logic       io_we_raw;

`ifdef TTLC_ARB_STARVE_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    assign forced     = (state_q == XFER) && core_req && (wait_cnt_q == 4'(HOST_WAIT_MAX));
    assign core_stall = forced & rst_n;
`else
    logic unused_wait_max;
    assign unused_wait_max = (HOST_WAIT_MAX != 0);
    assign forced          = 1'b0;
    assign core_stall      = 1'b0;
`endif

    assign host_slot  = (state_q == XFER) && (!core_req || forced);
    assign core_rdata = io_rdata;
    assign host_busy  = busy_q;
    assign host_ack   = ack_q;
    assign host_rdata = rdata_q;
    // A forced slot drops the core write entirely; reset blocks any write.
    assign io_we      = io_we_raw & rst_n;

    always_comb begin
        io_addr   = core_addr;
        io_wdata  = core_wdata;
        io_we_raw = core_req & core_we;
        if (host_slot) begin
            io_addr   = base_q + {5'd0, bit_idx_q};
            io_we_raw = we_q;
            io_wdata  = wdata_q[bit_idx_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bit_idx_d = bit_idx_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
`ifdef TTLC_ARB_STARVE_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    base_d    = host_addr;
                    we_d      = host_we;
                    wdata_d   = host_wdata;
                    bit_idx_d = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = XFER;
`ifdef TTLC_ARB_STARVE_EN
                    wait_cnt_d = 4'd0;
`endif
                end
            end
            XFER: begin
                if (host_slot) begin
                    if (!we_q) rdata_d[bit_idx_q] = io_rdata;
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef TTLC_ARB_STARVE_EN
                    wait_cnt_d = 4'd0;
`endif
                    if (bit_idx_q == 3'd7) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end
                end
`ifdef TTLC_ARB_STARVE_EN
                else if (wait_cnt_q != 4'd15) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= 8'd0;
            we_q      <= 1'b0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
`ifdef TTLC_ARB_STARVE_EN
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
`ifdef TTLC_ARB_STARVE_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_ttlc_io_arb.sv
// Bench for ttlc_io_arb: bit-memory I/O model plus a transaction-level reference of host/core effects.
module tb_ttlc_io_arb;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       core_req, core_we, core_wdata, core_rdata, core_stall;
    logic [7:0] core_addr;
    logic       host_req, host_we, host_busy, host_ack;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic [7:0] io_addr;
    logic       io_we, io_wdata, io_rdata;

    int checks = 0;
    int failures = 0;

    logic mem [256];
    bit   ref_mem [256];
    logic mem_init;
    int   init_mode;

    always #5 clk = ~clk;

    ttlc_io_arb #(.HOST_WAIT_MAX(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_addr(core_addr), .core_we(core_we),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_busy(host_busy), .host_ack(host_ack),
        .host_rdata(host_rdata), .io_addr(io_addr), .io_we(io_we),
        .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (init_mode == 1) ? i[0] : 1'b0;
        end else if (io_we) begin
            mem[io_addr] <= io_wdata;
        end
    end
    assign io_rdata = mem[io_addr];

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_wdata = 0; core_addr = 8'h00;
        host_req = 0; host_we = 0; host_addr = 8'h00; host_wdata = 8'h00;
    endtask

    task automatic init_mem(input int mode);
        mem_init = 1; init_mode = mode;
        for (int i = 0; i < 256; i++) ref_mem[i] = (mode == 1) ? i[0] : 1'b0;
        @(negedge clk);
        mem_init = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; core_req = 1; core_we = 1; host_req = 1; host_addr = 8'h33;
        @(negedge clk); #1;
        checks++; if (io_we !== 1'b0) begin failures++; $display("FAIL reset_io_we: got %b want 0", io_we); end
        @(negedge clk); #1;
        checks++;
        if ({host_busy, host_ack, core_stall, host_rdata} !== 11'd0) begin
            failures++; $display("FAIL reset_outputs: busy=%b ack=%b stall=%b rdata=%h want all 0",
                                 host_busy, host_ack, core_stall, host_rdata);
        end
        idle_inputs(); rst_n = 1;
        @(negedge clk); #1;
        checks++;
        if ({host_busy, host_ack, core_stall, host_rdata} !== 11'd0) begin
            failures++; $display("FAIL post_reset: busy=%b ack=%b stall=%b rdata=%h want all 0",
                                 host_busy, host_ack, core_stall, host_rdata);
        end
    endtask

    task automatic test_uncontended_write();
        logic [7:0] exp_b;
        logic [2:0] k;
        int pulses, ack_at, bad;
        exp_b = 8'hA5; pulses = 0; ack_at = -1; bad = 0; k = 0;
        @(negedge clk);
        idle_inputs(); host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = exp_b;
        #1;
        checks++; if (host_busy !== 1'b0) begin failures++; $display("FAIL wr_idle_busy: got %b want 0", host_busy); end
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk); host_req = 0; #1;
            if (io_we === 1'b1) begin
                if (pulses < 8) begin
                    k = 3'(pulses);
                    if (io_addr !== 8'h10 + 8'(pulses) || io_wdata !== exp_b[k]) bad++;
                end
                pulses++;
            end
            if (host_ack === 1'b1 && ack_at < 0) ack_at = t;
        end
        for (int i = 0; i < 8; i++) ref_mem[8'h10 + i] = exp_b[i];
        checks++; if (pulses != 8) begin failures++; $display("FAIL wr_pulses: got %0d want 8", pulses); end
        checks++; if (bad != 0) begin failures++; $display("FAIL wr_addr_data: got %0d bad pulses want 0", bad); end
        checks++; if (ack_at != 9) begin failures++; $display("FAIL wr_ack_time: got %0d want 9", ack_at); end
    endtask

    task automatic test_read_wrap();
        int ack_at, bad;
        logic [7:0] got;
        ack_at = -1; bad = 0; got = 8'h00;
        init_mem(1);
        idle_inputs(); host_req = 1; host_we = 0; host_addr = 8'hFE; host_wdata = 8'hFF;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk); host_req = 0; #1;
            if (t <= 8 && (io_addr !== 8'hFE + 8'(t - 1) || io_we !== 1'b0)) bad++;
            if (host_ack === 1'b1 && ack_at < 0) begin ack_at = t; got = host_rdata; end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rd_wrap_addr: got %0d bad cycles want 0", bad); end
        checks++; if (ack_at != 9) begin failures++; $display("FAIL rd_ack_time: got %0d want 9", ack_at); end
        checks++; if (got !== 8'hAA) begin failures++; $display("FAIL rd_wrap_data: got %h want aa", got); end
    endtask

    task automatic test_starvation();
        int stalls, bad_pos, bad_we, ack_at;
        stalls = 0; bad_pos = 0; bad_we = 0; ack_at = -1;
        init_mem(0);
        @(negedge clk);
        idle_inputs(); core_req = 1; host_req = 1; host_we = 0; host_addr = 8'h00;
        #1;
`ifdef TTLC_ARB_STARVE_EN
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            host_req = 0; core_we = 1'($urandom); core_wdata = 1'($urandom);
            core_addr = 8'($urandom_range(128, 255));
            #1;
            if (core_stall === 1'b1) begin
                stalls++;
                if (t % 5 != 0) bad_pos++;
                if (io_we !== 1'b0) bad_we++;
            end
            if (host_ack === 1'b1 && ack_at < 0) ack_at = t;
        end
        checks++; if (stalls != 8) begin failures++; $display("FAIL starve_stalls: got %0d want 8", stalls); end
        checks++; if (bad_pos != 0) begin failures++; $display("FAIL starve_period: got %0d off-slot stalls want 0", bad_pos); end
        checks++; if (bad_we != 0) begin failures++; $display("FAIL starve_we_supp: got %0d core writes leaked want 0", bad_we); end
        checks++; if (ack_at != 1 + 8 * (W + 1)) begin
            failures++; $display("FAIL starve_ack_time: got %0d want %0d", ack_at, 1 + 8 * (W + 1)); end
`else
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk); host_req = 0; core_addr = 8'($urandom_range(128, 255)); #1;
            if (core_stall === 1'b1) stalls++;
            if (host_busy !== 1'b1) bad_pos++;
        end
        checks++; if (stalls != 0) begin failures++; $display("FAIL nostarve_stall: got %0d stalls want 0", stalls); end
        checks++; if (bad_pos != 0) begin failures++; $display("FAIL nostarve_busy: got %0d idle cycles want 0", bad_pos); end
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk); core_req = 0; #1;
            if (host_ack === 1'b1 && ack_at < 0) ack_at = t;
        end
        checks++; if (ack_at != 8) begin failures++; $display("FAIL nostarve_drain: got %0d want 8", ack_at); end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int acks, ack_at;
        logic [7:0] got;
        acks = 0; ack_at = -1; got = 8'h00;
        init_mem(0);
        idle_inputs(); host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'hFF;
        for (int t = 1; t <= 3; t++) begin @(negedge clk); host_req = 0; end
        @(negedge clk); rst_n = 0; #1;
        checks++; if (io_we !== 1'b0) begin failures++; $display("FAIL mid_rst_io_we: got %b want 0", io_we); end
        @(negedge clk); rst_n = 1; #1;
        checks++; if (host_busy !== 1'b0 || io_we !== 1'b0) begin
            failures++; $display("FAIL mid_rst_after: busy=%b io_we=%b want 0 0", host_busy, io_we); end
        for (int t = 0; t < 12; t++) begin
            if (host_ack === 1'b1) acks++;
            @(negedge clk); #1;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL mid_rst_ack: got %0d acks want 0", acks); end
        checks++; if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !== 4'b0111) begin
            failures++; $display("FAIL mid_rst_partial: got %b want 0111",
                                 {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}); end
        for (int i = 0; i < 3; i++) ref_mem[8'h40 + i] = 1'b1;
        host_req = 1; host_we = 0; host_addr = 8'h40;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk); host_req = 0; #1;
            if (t == 1 && host_busy !== 1'b1) begin
                checks++; failures++; $display("FAIL mid_rst_reaccept: busy=%b want 1", host_busy); end
            if (host_ack === 1'b1 && ack_at < 0) begin ack_at = t; got = host_rdata; end
        end
        checks++; if (ack_at != 9 || got !== 8'h07) begin
            failures++; $display("FAIL mid_rst_newxfer: ack_at=%0d rdata=%h want 9 07", ack_at, got); end
    endtask

    task automatic test_collision();
        int ack_at;
        logic [7:0] got;
        ack_at = -1; got = 8'h00;
        init_mem(0);
        idle_inputs(); host_req = 1; host_we = 0; host_addr = 8'h20;
        @(negedge clk);
        host_req = 0; core_req = 1; core_we = 1; core_wdata = 1; core_addr = 8'h20;
        #1;
        checks++; if (core_stall !== 1'b0 || io_we !== 1'b1 || io_addr !== 8'h20) begin
            failures++; $display("FAIL coll_core_owns: stall=%b io_we=%b io_addr=%h want 0 1 20",
                                 core_stall, io_we, io_addr); end
        ref_mem[8'h20] = 1'b1;
        for (int t = 2; t <= 20; t++) begin
            @(negedge clk); idle_inputs(); #1;
            if (host_ack === 1'b1 && ack_at < 0) begin ack_at = t; got = host_rdata; end
        end
        checks++; if (ack_at < 0 || got !== 8'h01) begin
            failures++; $display("FAIL coll_rdata: ack_at=%0d rdata=%h want 01", ack_at, got); end
    endtask

    task automatic test_random();
        int p, ack_at, bad_pass, bad_stall;
        logic [7:0] base, wd, exp_b;
        logic we;
        init_mem(0);
        bad_pass = 0; bad_stall = 0;
        for (int n = 0; n < 24; n++) begin
            base = 8'($urandom_range(0, 8'h70)); we = 1'($urandom); wd = 8'($urandom);
            p = $urandom_range(0, 70);
            ack_at = -1;
            for (int t = 0; t < 300 && ack_at < 0; t++) begin
                @(negedge clk);
                host_req = (t == 0); host_we = we; host_addr = base; host_wdata = wd;
                core_req = ($urandom_range(0, 99) < p); core_we = 1'($urandom);
                core_wdata = 1'($urandom); core_addr = 8'($urandom_range(128, 255));
                #1;
`ifndef TTLC_ARB_STARVE_EN
                if (core_stall !== 1'b0) bad_stall++;
`endif
                if (core_rdata !== io_rdata) bad_pass++;
                if (core_req && core_stall === 1'b0) begin
                    if ({io_addr, io_we, io_wdata} !== {core_addr, core_we, core_wdata}) bad_pass++;
                    if (core_we) ref_mem[core_addr] = core_wdata;
                end
                if (host_ack === 1'b1) ack_at = t;
            end
            for (int i = 0; i < 8; i++) exp_b[i] = ref_mem[base + 8'(i)];
            checks++;
            if (ack_at < 0) begin
                failures++; $display("FAIL rand_timeout: xfer %0d no ack within 300 cycles", n);
            end else if (!we && host_rdata !== exp_b) begin
                failures++; $display("FAIL rand_rdata: xfer %0d got %h want %h", n, host_rdata, exp_b);
            end
`ifdef TTLC_ARB_STARVE_EN
            checks++; if (ack_at > 1 + 8 * (W + 1)) begin
                failures++; $display("FAIL rand_latency: xfer %0d ack_at=%0d max %0d", n, ack_at, 1 + 8 * (W + 1)); end
`endif
            if (we) for (int i = 0; i < 8; i++) ref_mem[base + 8'(i)] = wd[i];
        end
        checks++; if (bad_pass != 0) begin failures++; $display("FAIL rand_passthru: got %0d bad cycles want 0", bad_pass); end
        checks++; if (bad_stall != 0) begin failures++; $display("FAIL rand_stall: got %0d stalls want 0", bad_stall); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0; mem_init = 1; init_mode = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 1'b0;
        test_reset();
        mem_init = 0;
        test_uncontended_write();
        test_read_wrap();
        test_starvation();
        test_reset_mid();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ttlc_io_arb.md
# ttlc_io_arb

Arbiter and byte sequencer that shares the bit-addressed TTLC I/O space between the MC14500 logic-controller core and a host configuration/debug port. The core issues single-bit accesses every cycle and has priority. The host issues 8-bit byte transfers, which this block serializes into eight consecutive bit accesses on the shared I/O port. It sits between the core/host and the `ttlc_io` instance.

## Interface
- `HOST_WAIT_MAX`, default 4: consecutive lost cycles after which the host gets a forced slot; legal range 1..15.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `core_req` in 1: core drives a bit access this cycle.
- `core_addr` in 8: core bit address.
- `core_we` in 1: core write enable.
- `core_wdata` in 1: core write bit.
- `core_rdata` out 1: read bit returned to the core; equals `io_rdata`.
- `core_stall` out 1: core access not performed this cycle; the core holds its request.
- `host_req` in 1: host byte-transfer request, level.
- `host_we` in 1: 1 selects byte write, 0 selects byte read.
- `host_addr` in 8: base bit address of the byte.
- `host_wdata` in 8: write byte; bit i goes to address base+i.
- `host_busy` out 1: transfer in progress.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out 8: read byte; valid from the `host_ack` cycle until the next transfer is accepted.
- `io_addr` out 8: to the I/O block address input.
- `io_we` out 1: to the I/O block write enable.
- `io_wdata` out 1: to the I/O block data input.
- `io_rdata` in 1: combinational read bit from the I/O block.

## Operation
**FSM states: IDLE, XFER, DONE.**
- **IDLE.** `host_busy`=0.
  - If `host_req`=1, latch `host_addr`, `host_we` and `host_wdata`; clear `bit_idx` (3 bits) and `wait_cnt` (4 bits); go to XFER.
- **XFER.** Each cycle the block picks one owner of the I/O port.
  - **Host slot:** taken when `core_req`=0, or when a forced slot is active.
    - `io_addr` = (base + `bit_idx`) mod 256; 8-bit wrap, so base 0xFE gives 0xFE,0xFF,0x00..0x05.
    - `io_we` = latched `we`; `io_wdata` = `wdata[bit_idx]`.
    - On a read, `io_rdata` is captured into `host_rdata[bit_idx]` at the clock edge.
    - `bit_idx` increments and `wait_cnt` clears.
    - After the slot with `bit_idx`=7, go to DONE.
  - **Core slot:** `io_addr`/`io_we`/`io_wdata` = `core_*`; `core_stall`=0; `wait_cnt` increments, saturating at 15.
- **Forced slot.** Active when `wait_cnt` == `HOST_WAIT_MAX` and `core_req`=1.
  - Host takes the port for exactly one bit; `core_stall`=1 for that cycle.
  - Core write suppressed: `io_we` follows the host only.
- **DONE.** `host_ack`=1 and `host_busy`=1 for one cycle, then go to IDLE. `host_req` is not sampled in DONE.
- **Outside host slots.** `io_*` follows `core_*`. With `core_req`=0 and no host slot, `io_we`=0.
- **core_rdata.** Always equals `io_rdata`; meaningful only when `core_req`=1 and `core_stall`=0.
- **Reset value of every output** (while `rst_n`=0 at a clock edge, and the cycle after):
  - `host_busy`=0, `host_ack`=0, `host_rdata`=0, `core_stall`=0.
  - `io_we`=0 combinationally whenever `rst_n`=0.
  - State returns to IDLE.
  - Reset mid-transfer aborts the transfer with no ack. Bits already written stay written.
- **`host_req` while busy** is ignored. A host holding `host_req` through DONE starts its next transfer one cycle after the ack.
- **Simultaneous core write and host read of the same address:** the core owns the port that cycle. The host bit is read in a later slot and returns the newly written value.

## Timing
- Request accepted at edge N → XFER from cycle N+1.
- Uncontended byte: host bits in cycles N+1..N+8, `host_ack` in N+9.
- Worst case with continuous core traffic: each bit waits `HOST_WAIT_MAX` core cycles, so ack in cycle N+1+8×(`HOST_WAIT_MAX`+1).
- Core latency is zero cycles, combinational passthrough, except on forced-slot cycles.

## Configuration
- **`TTLC_ARB_STARVE_EN` defined:** the forced-slot mechanism is compiled in as described above.
- **`TTLC_ARB_STARVE_EN` undefined:**
  - The host gets a slot only when `core_req`=0.
  - `core_stall` is tied to 0.
  - `wait_cnt` logic is removed, and `HOST_WAIT_MAX` is ignored.
  - A transfer may wait indefinitely.

## Test plan
- **Uncontended write:** reset, `core_req`=0, host writes 0xA5 at base 0x10.
  - `io_we` pulses at addresses 0x10..0x17 with data 1,0,1,0,0,1,0,1.
  - `host_ack` arrives 9 cycles after acceptance.
- **Uncontended read with wrap:** base 0xFE, `io_rdata` model returns bit = address[0].
  - Addresses 0xFE,0xFF,0x00..0x05 are issued.
  - `host_rdata` = 0xAA.
- **Starvation (macro on, `HOST_WAIT_MAX`=4):** `core_req`=1 every cycle, host reads a byte.
  - `core_stall`=1 on exactly 8 cycles, every 5th cycle.
  - `host_ack` arrives at N+41.
- **Starvation (macro off):** same stimulus. `host_busy` stays 1 for 100 cycles and `core_stall` is never 1. Dropping `core_req` completes the transfer in 8 cycles.
- **Reset mid-transfer:** assert `rst_n`=0 after 3 host bits of a write.
  - No `host_ack`; `host_busy`=0 and `io_we`=0 the next cycle.
  - A new transfer is then accepted normally.
- **Collision:** a core write of 1 to 0x20 and a host read at base 0x20 in the same cycle. `host_rdata[0]`=1 and the core is not stalled.
